// File: rtl/lut_arb_pkg.sv
// Shared constants, types and helpers for the lookup-table arbiter.
// Optional build macro used by the top: LUT_ARB_RSP_REG_EN.
package lut_arb_pkg;

  localparam int LUT_ADDR_W  = 5;
  localparam int LUT_DATA_W  = 32;
  localparam int LUT_N_REQ   = 4;
  // Widest requester count the arbiter supports; onehot() is sized for it.
  localparam int LUT_MAX_REQ = 8;

  typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
  typedef logic [LUT_DATA_W-1:0] lut_data_t;

  // One-hot decode of a requester index, sized for the widest build.
  // Callers truncate the result to their own requester count.
  function automatic logic [LUT_MAX_REQ-1:0] onehot(input logic [2:0] id);
    return LUT_MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/lookup_table_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request scanning from ptr
// upward, with wrap-around. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_grant
);

  logic [IW-1:0] j;

  // Rotating priority scan; the first hit wins and later hits are ignored.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/lookup_table_arbiter.sv
// Round-robin arbiter sharing one registered-read lookup table between
// N_REQ requesters. One grant per cycle; the table word comes back one
// cycle later and is steered to the owner via a one-hot strobe.
// Build macro LUT_ARB_RSP_REG_EN adds an output register stage
// (latency 2 instead of 1, throughput unchanged).
module lookup_table_arbiter
  import lut_arb_pkg::*;
#(
  parameter int N_REQ      = LUT_N_REQ,
  parameter int ADDR_WIDTH = LUT_ADDR_W,
  parameter int DATA_WIDTH = LUT_DATA_W,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ADDR_WIDTH-1:0]       lut_addr,
  input  logic [DATA_WIDTH-1:0]       lut_data
);

  logic [ID_WIDTH-1:0] ptr;
  logic [N_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0] gidx;
  logic                any_grant;
  logic                inflight_v;
  logic [ID_WIDTH-1:0] inflight_id;
  logic [N_REQ-1:0]    rsp_valid_c;
  logic [ID_WIDTH-1:0] rsp_id_c;

  // Requests are masked during reset so nothing is granted or addressed.
  rr_arbiter #(.N(N_REQ), .IW(ID_WIDTH)) u_rr (
    .req       (req_valid & {N_REQ{~rst}}),
    .ptr       (ptr),
    .grant     (grant),
    .idx       (gidx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  // Table address follows the winner in the same cycle; zero when idle.
  always_comb begin
    lut_addr = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) lut_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Pointer advance past the winner, plus the one-deep in-flight tag that
  // tracks who owns the table word arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      inflight_v  <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight_v <= any_grant;
      if (any_grant) begin
        inflight_id <= gidx;
        ptr         <= (int'(gidx) == N_REQ-1) ? '0 : gidx + 1'b1;
      end
    end
  end

  // A lookup still in flight when reset asserts is suppressed immediately.
  assign rsp_valid_c = (inflight_v && !rst) ? N_REQ'(onehot(3'(inflight_id))) : '0;
  assign rsp_id_c    = rst ? '0 : inflight_id;

`ifdef LUT_ARB_RSP_REG_EN
  logic [N_REQ-1:0]      rsp_valid_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  // Extra output stage to cut the table-to-requester timing path.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_c;
      rsp_id_q    <= rsp_id_c;
      rsp_data_q  <= lut_data;
    end
  end

  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_id    = rst ? '0 : rsp_id_q;
  assign rsp_data  = rsp_data_q;
`else
  assign rsp_valid = rsp_valid_c;
  assign rsp_id    = rsp_id_c;
  assign rsp_data  = lut_data;
`endif

endmodule

// File: tb/tb_lookup_table_arbiter.sv
// Directed, table-driven bench for lookup_table_arbiter (N_REQ=4).
// Expected grants and table addresses are hand-written per row; expected
// responses are those grants shifted by the build's response latency.
module tb_lookup_table_arbiter;
  import lut_arb_pkg::*;

`ifdef LUT_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [19:0] req_addr = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic [1:0]  rsp_id;
  lut_data_t   rsp_data;
  lut_addr_t   lut_addr;
  lut_data_t   lut_data = '1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lookup_table_arbiter #(.N_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data)
  );

  function automatic lut_data_t tbl(input lut_addr_t a);
    return 32'h3C00_0000 ^ (32'(a) * 32'h0104_2081);
  endfunction

  // Registered-read table model; output forced to all-ones while in reset.
  always @(posedge clk) lut_data <= rst ? '1 : tbl(lut_addr);

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    logic [19:0] addr;
    logic [3:0] ready;
    logic [4:0] lut;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, logic [3:0] v, logic [4:0] a0, logic [4:0] a1,
                              logic [4:0] a2, logic [4:0] a3, logic [3:0] er, logic [4:0] el);
    vec_t t;
    t.rst = r; t.valid = v; t.addr = {a3, a2, a1, a0}; t.ready = er; t.lut = el;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    // Reset held with everyone requesting.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 4'b1111, 3, 7, 11, 31, 4'b0000, 0));
    // Round-robin with all valid: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(mk(0, 4'b1111, 3, 7, 11, 31, 4'b0001, 3));
      vecs.push_back(mk(0, 4'b1111, 3, 7, 11, 31, 4'b0010, 7));
      vecs.push_back(mk(0, 4'b1111, 3, 7, 11, 31, 4'b0100, 11));
      vecs.push_back(mk(0, 4'b1111, 3, 7, 11, 31, 4'b1000, 31));
    end
    // Single requester 2 streaming every address; ptr ends at 3.
    for (int i = 0; i < 32; i++)
      vecs.push_back(mk(0, 4'b0100, 0, 0, 5'(i), 0, 4'b0100, 5'(i)));
    // Wrap and skip from ptr=3 with only 1 and 3 requesting.
    vecs.push_back(mk(0, 4'b1010, 0, 9, 0, 20, 4'b1000, 20));
    vecs.push_back(mk(0, 4'b1010, 0, 9, 0, 20, 4'b0010, 9));
    vecs.push_back(mk(0, 4'b1010, 0, 9, 0, 20, 4'b1000, 20));
    vecs.push_back(mk(0, 4'b1010, 0, 9, 0, 20, 4'b0010, 9));
    // Idle: no grant, ptr held at 2.
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
    // Grant 1, then reset lands while its lookup is in flight.
    vecs.push_back(mk(0, 4'b0010, 0, 5, 0, 0, 4'b0010, 5));
    vecs.push_back(mk(1, 4'b1010, 0, 5, 0, 20, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b1010, 0, 5, 0, 20, 4'b0000, 0));
    // After release ptr is back to 0: req 1 first, then 3.
    vecs.push_back(mk(0, 4'b1010, 0, 5, 0, 20, 4'b0010, 5));
    vecs.push_back(mk(0, 4'b1000, 0, 5, 0, 20, 4'b1000, 20));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      logic [3:0] ev;
      logic [1:0] eid;
      lut_data_t  ed;
      bit         ok;
      @(negedge clk);
      rst = vecs[k].rst; req_valid = vecs[k].valid; req_addr = vecs[k].addr;
      #2;
      chk("req_ready", k, 32'(req_ready), 32'(vecs[k].ready));
      chk("lut_addr",  k, 32'(lut_addr),  32'(vecs[k].lut));
      ev = '0; eid = '0; ed = '0; ok = 0;
      if (k >= LAT && vecs[k-LAT].ready != 0) begin
        ok = 1;
        for (int j = k-LAT+1; j <= k; j++) if (vecs[j].rst) ok = 0;
      end
      if (ok) begin
        ev = vecs[k-LAT].ready;
        for (int b = 0; b < 4; b++) if (ev[b]) eid = 2'(b);
        ed = tbl(vecs[k-LAT].lut);
      end
      chk("rsp_valid", k, 32'(rsp_valid), 32'(ev));
      if (ok) begin
        chk("rsp_id",   k, 32'(rsp_id), 32'(eid));
        chk("rsp_data", k, rsp_data, ed);
      end else if (vecs[k].rst) begin
        chk("rsp_id_rst", k, 32'(rsp_id), 32'd0);
      end
      if (k > 0 && vecs[k-1].rst)
        chk("rsp_data_post_rst", k, rsp_data, (LAT == 1) ? 32'hFFFF_FFFF : 32'h0);
    end

    // Isolated request from req 0: count cycles to its response strobe.
    begin
      int  n;
      bit  seen;
      @(negedge clk);
      req_valid = 4'b0001; req_addr = 20'd17;
      #2;
      chk("lat_grant", 0, 32'(req_ready), 32'h1);
      seen = 0; n = 0;
      while (!seen && n < 6) begin
        @(negedge clk);
        req_valid = '0; req_addr = '0;
        #2;
        n++;
        if (rsp_valid != 0) begin
          seen = 1;
          chk("lat_cycles", 0, 32'(n), 32'(LAT));
          chk("lat_valid",  0, 32'(rsp_valid), 32'h1);
          chk("lat_data",   0, rsp_data, tbl(5'd17));
        end
      end
      if (!seen) chk("lat_timeout", 0, 32'(n), 32'(LAT));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lookup_table_arbiter.md
Name: lookup_table_arbiter

Overview:
- Shares one registered-read lookup table (1-cycle read latency; output forced to all-ones while the table's rst is high) between N_REQ requesters.
- Round-robin grant of at most one request per cycle; drives the table address and routes the returned word back to the granted requester.
- Sits between the cipher/keystream datapaths and the single lookup_table instance; full throughput of one lookup per cycle.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 5, table address width.
- DATA_WIDTH, 32, table word width.
- ID_WIDTH, $clog2(N_REQ), width of the grant index.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  N_REQ  per-requester request valid.
- req_addr  input  N_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  output  N_REQ  one-hot grant, combinational.
- rsp_valid  output  N_REQ  one-hot response strobe.
- rsp_id  output  ID_WIDTH  index of the requester owning rsp_data.
- rsp_data  output  DATA_WIDTH  looked-up word, shared bus.
- lut_addr  output  ADDR_WIDTH  to the table addr input.
- lut_data  input  DATA_WIDTH  from the table data output.

Behaviour:
- Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i]. The requester holds valid and addr stable until ready. Valid must not depend on ready.
- Arbitration: rr pointer ptr (ID_WIDTH bits, reset 0). Grant the first i with req_valid[i] set, scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - On a grant to g, ptr <= (g+1) mod N_REQ. With no grant, ptr is held.
- Grant timing:
  - req_ready is asserted only when rst=0.
  - lut_addr = req_addr of the granted requester, or 0 when there is no grant.
  - lut_addr is combinational, so the table samples it at the same edge.
- Pipeline: registered inflight_v and inflight_id, both reset to 0.
  - At the grant edge: inflight_v <= 1, inflight_id <= g. Otherwise inflight_v <= 0.
- Response (latency 1 cycle after the grant cycle):
  - rsp_valid = inflight_v ? onehot(inflight_id) : 0.
  - rsp_id = inflight_id.
  - rsp_data = lut_data, passed through combinationally.
  - No response backpressure: requesters must accept on the strobe.
- Back-to-back: grants in consecutive cycles produce responses in consecutive cycles, in grant order.
- Fairness: with all requesters valid continuously, grants are 0,1,2,3,0,... Each requester waits at most N_REQ-1 cycles.
- Single requester: it is granted every cycle, and ptr tracks g+1.
- Reset:
  - While rst=1: req_ready=0, rsp_valid=0, rsp_id=0, lut_addr=0.
  - An in-flight lookup at the rst edge is dropped with no response. Its requester must re-request.
  - The first cycle after rst deasserts can already grant, and priority starts at requester 0.
- rsp_data is don't-care when rsp_valid=0. It is all-ones during and immediately after reset.

Optional Feature:
- Macro LUT_ARB_RSP_REG_EN.
- Defined: adds an output register stage.
  - rsp_valid, rsp_id and rsp_data are registered one more cycle. Latency becomes 2 cycles from grant; throughput is unchanged.
  - The stage resets to rsp_valid=0, rsp_id=0, rsp_data=0.
- Undefined: latency 1, combinational rsp_data path as above.

Decomposition:
- Package lut_arb_pkg holds:
  - default constants LUT_ADDR_W=5, LUT_DATA_W=32, LUT_N_REQ=4;
  - typedef lut_addr_t, lut_data_t;
  - function onehot(id) returning N_REQ bits.
- Sub-module rr_arbiter (N parameter): req vector and ptr in; one-hot grant, grant index and any_grant out. It is combinational and the ptr register stays in the parent.

Test Plan:
- Reset and idle: hold rst 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0 throughout. Release rst -> first grant to req 0, and rsp_valid=0001 one cycle later with rsp_data = table[addr0].
- Single requester: req 2 streams addrs 0..31 continuously -> req_ready[2] high every cycle. rsp_valid=0100 every cycle, rsp_data sequence = table[0..31], latency 1.
- Round-robin: all 4 valid with addrs 3,7,11,31 held for 8 cycles -> grants 0,1,2,3,0,1,2,3. rsp_id sequence is the same, delayed 1, with data table[3], table[7], table[11], table[31] repeating.
- Wrap and skip: ptr=3, only req 1 and req 3 valid -> grant 3, then 1, then 3. Req 0 and req 2 never get ready.
- Mid-operation reset: grant req 1 at cycle t, rst=1 at t+1 -> no rsp_valid at t+1. After release with req 1 and req 3 valid, req 1 is granted first (ptr=0).
- LUT_ARB_RSP_REG_EN defined: repeat the round-robin test -> identical rsp sequence shifted by exactly one extra cycle. Output regs are 0 after reset.
